data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 117 +++++++++++
 tb/tb_data_mem_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with a sequential 64-bit load/store port.
// Each access moves one byte per cycle, little-endian, then pulses o_valid.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);
  localparam int unsigned END_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  logic [7:0]        mem [0:MEM_BYTES-1];

  state_e            state_q;
  logic [2:0]        k_q;
  logic [IDX_W-1:0]  base_q;
  logic              is_store_q;
  logic [DATA_W-1:0] shift_q;
  logic              o_valid_q;
  logic              o_err_q;
  logic              o_busy_q;
  logic [DATA_W-1:0] o_data_q;

  logic              req_c;
  logic              out_of_range_c;
  logic [END_W-1:0]  end_addr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [7:0]        rd_byte_c;
  logic [DATA_W-1:0] shift_d;

  // Request decode, range check and current byte address/data.
  always_comb begin
    req_c          = i_MemRead | i_MemWrite;
    end_addr_c     = {1'b0, i_addr[IDX_W-1:0]} + END_W'(7);
    out_of_range_c = (end_addr_c >= END_W'(MEM_BYTES)) || ((i_addr >> IDX_W) != '0);
    idx_c          = base_q + IDX_W'(k_q);
    rd_byte_c      = mem[idx_c];
    // One register serves both directions: store bytes leave from the bottom,
    // load bytes enter at the top, so after eight shifts byte 0 sits at [7:0].
    shift_d        = {rd_byte_c, shift_q[DATA_W-1:8]};
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      is_store_q <= 1'b0;
      shift_q    <= '0;
      o_valid_q  <= 1'b0;
      o_err_q    <= 1'b0;
      o_busy_q   <= 1'b0;
      o_data_q   <= '0;
    end else begin
      o_valid_q <= 1'b0;
      o_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_c) begin
            o_busy_q   <= 1'b1;
            is_store_q <= i_MemWrite;
            base_q     <= i_addr[IDX_W-1:0];
            shift_q    <= i_data;
            k_q        <= '0;
            if (out_of_range_c) begin
              state_q   <= RESP;
              o_valid_q <= 1'b1;
              o_err_q   <= 1'b1;
              o_data_q  <= '0;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          shift_q <= shift_d;
          k_q     <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_q   <= RESP;
            o_valid_q <= 1'b1;
            if (!is_store_q) o_data_q <= shift_d;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          o_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte write port; contents are never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == XFER && is_store_q) mem[idx_c] <= shift_q[7:0];
  end

  assign o_valid = o_valid_q;
  assign o_err   = o_err_q;
  assign o_busy  = o_busy_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued at issue
// and matched against each o_valid pulse.
module tb_data_mem_ctrl;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk;
  logic        i_rst;
  logic [63:0] i_addr;
  logic [63:0] i_data;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic        o_valid;
  logic [63:0] o_data;
  logic        o_busy;
  logic        o_err;

  data_mem_ctrl dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_MemRead  (i_MemRead),
    .i_MemWrite (i_MemWrite),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl [0:MEM_BYTES-1];
  logic [63:0] last_data;
  int          n_chk;
  int          n_pass;
  int          n_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request at a negedge, track it to completion; ends on a negedge.
  task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input bit poke);
    exp_t e;
    logic err;
    int   n;
    int   busy_n;
    int   v0;
    err = (addr >= 64'(MEM_BYTES - 7));
    if (err) last_data = '0;
    else if (wr) for (int i = 0; i < 8; i++) mdl[addr + 64'(i)] = data[8*i +: 8];
    else for (int i = 0; i < 8; i++) last_data[8*i +: 8] = mdl[addr + 64'(i)];
    e.err  = err;
    e.data = last_data;
    exp_q.push_back(e);
    i_addr = addr; i_data = data; i_MemRead = rd; i_MemWrite = wr;
    @(posedge clk); #1;
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    i_addr = {$urandom, $urandom}; i_data = {$urandom, $urandom};
    v0 = n_valid; n = 0; busy_n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (o_busy === 1'b1) busy_n++;
      if (poke && n == 3) i_MemRead = 1'b1;
      else if (poke && n == 4) i_MemRead = 1'b0;
      if (o_valid === 1'b1) break;
    end
    check("latency", 64'(n), err ? 64'd1 : 64'd9);
    check("busy_cycles", 64'(busy_n), err ? 64'd1 : 64'd9);
    @(negedge clk);
    check("idle_after", 64'({o_busy, o_valid}), 64'd0);
    if (poke) check("poke_one_valid", 64'(n_valid - v0), 64'd1);
  endtask

  task automatic check_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) check($sformatf("mem[%0h]", a), 64'(dut.mem[a]), 64'(mdl[a]));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_valid = 0; last_data = '0;
    i_rst = 1'b1; i_addr = '0; i_data = '0; i_MemRead = 1'b0; i_MemWrite = 1'b0;

    // Response monitor
    fork
      forever begin
        @(negedge clk);
        if (o_valid === 1'b1) begin
          exp_t e;
          n_valid++;
          if (exp_q.size() == 0) check("unexpected_valid", 64'(o_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("resp_err", 64'(o_err), 64'(e.err));
            check("resp_data", o_data, e.data);
          end
        end else begin
          check("err_idle", 64'(o_err), 64'd0);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", 64'({o_valid, o_busy, o_err}), 64'd0);
    check("rst_data", o_data, 64'd0);

    // Bring a known memory image into the low region and the top word.
    for (int a = 0; a < 'h80; a += 8) do_req(1'b0, 1'b1, 64'(a), {$urandom, $urandom}, 1'b0);
    do_req(1'b0, 1'b1, 64'h3F8, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);

    // Aligned store then load of the same word.
    do_req(1'b0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("mem10", 64'(dut.mem['h10]), 64'hEF);
    check("mem17", 64'(dut.mem['h17]), 64'h01);
    check_mem('h0F, 'h18);
    do_req(1'b1, 1'b0, 64'h10, '0, 1'b0);
    check("load10", o_data, 64'h0123_4567_89AB_CDEF);

    // Range edges and high address bits.
    do_req(1'b1, 1'b0, 64'h3F9, '0, 1'b0);
    check("oor_data", o_data, 64'd0);
    do_req(1'b1, 1'b0, 64'h3F8, '0, 1'b0);
    do_req(1'b1, 1'b0, 64'h8000_0000_0000_0010, '0, 1'b0);
    do_req(1'b0, 1'b1, 64'h3FC, 64'h1111_2222_3333_4444, 1'b0);
    check_mem('h3F8, 'h3FF);

    // Simultaneous read and write behaves as a store.
    do_req(1'b1, 1'b0, 64'h13, '0, 1'b0);
    do_req(1'b1, 1'b1, 64'h20, 64'hFF, 1'b0);
    check("mem20", 64'(dut.mem['h20]), 64'hFF);
    check_mem('h1F, 'h28);

    // Load with a second request pulsed mid-transfer.
    do_req(1'b1, 1'b0, 64'h13, '0, 1'b1);

    // Unaligned store and loads that straddle it.
    do_req(1'b0, 1'b1, 64'h35, {$urandom, $urandom}, 1'b0);
    do_req(1'b1, 1'b0, 64'h30, '0, 1'b0);
    do_req(1'b1, 1'b0, 64'h38, '0, 1'b0);

    // Reset while a store is in flight.
    i_addr = 64'h40; i_data = 64'h1122_3344_5566_7788; i_MemWrite = 1'b1;
    @(posedge clk); #1 i_MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    mdl['h40] = 8'h88; mdl['h41] = 8'h77; mdl['h42] = 8'h66;
    last_data = '0;
    @(negedge clk);
    check("abort_outputs", 64'({o_valid, o_busy, o_err}), 64'd0);
    check("abort_data", o_data, 64'd0);
    repeat (12) @(negedge clk);
    check("abort_no_valid", 64'(exp_q.size()), 64'd0);
    check_mem('h3E, 'h49);

    // Mixed random traffic including occasional out-of-range hits.
    for (int t = 0; t < 24; t++) begin
      logic [63:0] a;
      a = (t % 6 == 5) ? 64'($urandom_range(1017, 1023)) : 64'($urandom_range(0, 'h78));
      if ($urandom_range(0, 1) == 1) do_req(1'b0, 1'b1, a, {$urandom, $urandom}, 1'b0);
      else do_req(1'b1, 1'b0, a, '0, 1'b0);
    end
    check_mem(0, 'h7F);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
